// File: rtl/lcd_pixel_packer.sv
// lcd_pixel_packer: packs 2-bit grey pixels from an LCD scan stream into bytes
// (4 pixels per byte, first pixel in [7:6]) and buffers them in an 8-entry FIFO
// tagged with start-of-line / start-of-frame flags.
// Optional feature macro: LCD_PACKER_DROP_CNT_EN enables the saturating drop counter.
module lcd_pixel_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        pvalid,
  input  logic [1:0]  pixel,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        byte_sol,
  output logic        byte_sof,
  output logic        overflow,
  output logic [15:0] drop_cnt
);

  localparam int unsigned Depth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StWaitLine,
    StActive
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  acc_q, acc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        sol_pend_q, sol_pend_d;
  logic        sof_pend_q, sof_pend_d;
  // Staged byte {sof, sol, data}; written into the FIFO one cycle after completion.
  logic        push_q, push_d;
  logic [9:0]  push_byte_q, push_byte_d;
  logic [7:0]  packed_byte;

  logic [9:0]  mem_q [Depth];
  logic [2:0]  wr_ptr_q, rd_ptr_q;
  logic [3:0]  count_q;
  logic        fifo_empty, fifo_full, pop, wr_en, drop;
  logic [9:0]  head;
  logic        overflow_q;

  // Sync handling, pixel packing and byte staging; syncs act before the pixel.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sol_pend_d  = sol_pend_q;
    sof_pend_d  = sof_pend_q;
    push_d      = 1'b0;
    push_byte_d = push_byte_q;
    packed_byte = 8'h00;

    if (vsync) begin
      // A partial byte is dropped on a new frame.
      state_d    = StWaitLine;
      acc_d      = 8'h00;
      cnt_d      = 2'd0;
      sol_pend_d = 1'b1;
      sof_pend_d = 1'b1;
    end else if (hsync && (state_q == StActive)) begin
      // Flush a partial byte; unfilled positions are already zero.
      if (cnt_q != 2'd0) begin
        push_d      = 1'b1;
        push_byte_d = {sof_pend_q, sol_pend_q, acc_q};
        sof_pend_d  = 1'b0;
      end
      acc_d      = 8'h00;
      cnt_d      = 2'd0;
      sol_pend_d = 1'b1;
      state_d    = StWaitLine;
    end

    if (pvalid && (state_d != StIdle)) begin
      state_d     = StActive;
      packed_byte = acc_d | ({6'd0, pixel} << {2'd3 - cnt_d, 1'b0});
      if (cnt_d == 2'd3) begin
        push_d      = 1'b1;
        push_byte_d = {sof_pend_d, sol_pend_d, packed_byte};
        sof_pend_d  = 1'b0;
        sol_pend_d  = 1'b0;
        acc_d       = 8'h00;
        cnt_d       = 2'd0;
      end else begin
        acc_d = packed_byte;
        cnt_d = cnt_d + 2'd1;
      end
    end
  end

  // Packer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= 8'h00;
      cnt_q       <= 2'd0;
      sol_pend_q  <= 1'b0;
      sof_pend_q  <= 1'b0;
      push_q      <= 1'b0;
      push_byte_q <= 10'h000;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sol_pend_q  <= sol_pend_d;
      sof_pend_q  <= sof_pend_d;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
    end
  end

  // FIFO control; a pop frees the slot for a push in the same cycle when full.
  always_comb begin
    fifo_empty = (count_q == 4'd0);
    fifo_full  = (count_q == 4'(Depth));
    pop        = !fifo_empty && byte_ready;
    wr_en      = push_q && (!fifo_full || pop);
    drop       = push_q && fifo_full && !pop;
    head       = mem_q[rd_ptr_q];
    byte_valid = !fifo_empty;
    byte_data  = fifo_empty ? 8'h00 : head[7:0];
    byte_sol   = fifo_empty ? 1'b0 : head[8];
    byte_sof   = fifo_empty ? 1'b0 : head[9];
    overflow   = overflow_q;
  end

  // FIFO storage; contents are qualified by the occupancy count, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_byte_q;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 4'd0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 3'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 3'd1;
      end
      if (wr_en && !pop) begin
        count_q <= count_q + 4'd1;
      end else if (!wr_en && pop) begin
        count_q <= count_q - 4'd1;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as vsync wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (vsync) begin
      overflow_q <= 1'b0;
    end
  end

`ifdef LCD_PACKER_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating drop counter, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= 16'h0000;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'h0001;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_pixel_packer.sv
// Testbench for lcd_pixel_packer: directed scenarios plus randomized frames checked
// against a line/frame-level byte model.
module tb_lcd_pixel_packer;

  logic        clk;
  logic        rst;
  logic        hsync;
  logic        vsync;
  logic        pvalid;
  logic [1:0]  pixel;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        byte_sol;
  logic        byte_sof;
  logic        overflow;
  logic [15:0] drop_cnt;

  int checks;
  int failures;
  bit frame_first;
  logic [9:0] cap_q[$];
  logic [9:0] exp_q[$];

`ifdef LCD_PACKER_DROP_CNT_EN
  localparam logic [15:0] ExpDrops = 16'd2;
`else
  localparam logic [15:0] ExpDrops = 16'd0;
`endif

  lcd_pixel_packer dut (
    .clk        (clk),
    .rst        (rst),
    .hsync      (hsync),
    .vsync      (vsync),
    .pvalid     (pvalid),
    .pixel      (pixel),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_sol   (byte_sol),
    .byte_sof   (byte_sof),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit rnd_rdy();
    return $urandom_range(0, 3) != 0;
  endfunction

  // One cycle: drive inputs at the falling edge and record any handshake.
  task automatic step(input bit hs, input bit vs, input bit pv, input logic [1:0] px,
                      input bit rdy);
    hsync      = hs;
    vsync      = vs;
    pvalid     = pv;
    pixel      = px;
    byte_ready = rdy;
    if (byte_valid && rdy) cap_q.push_back({byte_sof, byte_sol, byte_data});
    @(negedge clk);
  endtask

  function automatic bit pick_rdy(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return rnd_rdy();
  endfunction

  task automatic emit(input logic [7:0] b, input bit sol);
    exp_q.push_back({frame_first, sol, b});
    frame_first = 1'b0;
  endtask

  // Drives n random pixels of one line and appends the bytes the line must yield.
  task automatic drive_line(input int n, input bit term_hsync, input int rdy_mode,
                            input bit gaps);
    logic [7:0] acc;
    logic [1:0] px;
    bit         line_first;
    acc        = 8'h00;
    line_first = 1'b1;
    for (int i = 0; i < n; i++) begin
      px = 2'($urandom_range(0, 3));
      if (gaps && ($urandom_range(0, 2) == 0)) step(0, 0, 0, 2'd0, pick_rdy(rdy_mode));
      step(0, 0, 1, px, pick_rdy(rdy_mode));
      acc = acc | (8'(px) << (2 * (3 - (i % 4))));
      if ((i % 4) == 3) begin
        emit(acc, line_first);
        line_first = 1'b0;
        acc        = 8'h00;
      end
    end
    if (term_hsync) begin
      step(1, 0, 0, 2'd0, pick_rdy(rdy_mode));
      if ((n % 4) != 0) emit(acc, line_first);
    end
  endtask

  task automatic drain(input string tag);
    int quiet;
    quiet = 0;
    for (int i = 0; (i < 200) && (quiet < 3); i++) begin
      step(0, 0, 0, 2'd0, 1);
      quiet = byte_valid ? 0 : quiet + 1;
    end
    check({tag, "_drain_done"}, 32'(quiet >= 3), 1);
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_count"}, cap_q.size(), exp_q.size());
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic pixels(input int n, input logic [1:0] v, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 1, v, rdy);
  endtask

  initial begin
    int lines;
    checks      = 0;
    failures    = 0;
    frame_first = 1'b0;
    rst         = 1'b1;
    hsync       = 1'b0;
    vsync       = 1'b0;
    pvalid      = 1'b0;
    pixel       = 2'd0;
    byte_ready  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_data", byte_data, 0);
    check("rst_byte_sol", byte_sol, 0);
    check("rst_byte_sof", byte_sof, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    step(0, 0, 0, 2'd0, 1);

    // Single byte with one-cycle push latency.
    step(0, 1, 0, 2'd0, 1);
    step(0, 0, 1, 2'd3, 1);
    step(0, 0, 1, 2'd2, 1);
    step(0, 0, 1, 2'd1, 1);
    step(0, 0, 1, 2'd0, 1);
    check("lat_not_yet_valid", byte_valid, 0);
    step(0, 0, 0, 2'd0, 0);
    check("lat_valid", byte_valid, 1);
    check("lat_data", byte_data, 8'hE4);
    check("lat_sol", byte_sol, 1);
    check("lat_sof", byte_sof, 1);
    exp_q.push_back(10'h3E4);
    drain("first");
    compare("first");

    // hsync pads a partial byte; next line starts with sol only.
    step(0, 1, 0, 2'd0, 1);
    pixels(6, 2'd1, 1);
    step(1, 0, 0, 2'd0, 1);
    pixels(4, 2'd2, 1);
    exp_q.push_back(10'h355);
    exp_q.push_back(10'h050);
    exp_q.push_back(10'h1AA);
    drain("pad");
    compare("pad");

    // Overflow: 10 bytes into a stalled 8-entry FIFO.
    step(0, 1, 0, 2'd0, 0);
    frame_first = 1'b1;
    drive_line(40, 0, 0, 0);
    step(0, 0, 0, 2'd0, 0);
    step(0, 0, 0, 2'd0, 0);
    check("ovf_flag", overflow, 1);
    check("ovf_drop_cnt", drop_cnt, ExpDrops);
    check("ovf_valid", byte_valid, 1);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    drain("ovf");
    compare("ovf");
    check("ovf_sticky", overflow, 1);

    // Full FIFO with simultaneous pop and push: nothing lost.
    step(0, 1, 0, 2'd0, 0);
    frame_first = 1'b1;
    check("ovf_cleared_by_vsync", overflow, 0);
    drive_line(36, 0, 0, 0);
    step(0, 0, 0, 2'd0, 1);
    step(0, 0, 0, 2'd0, 0);
    check("full_pp_overflow", overflow, 0);
    check("full_pp_one_popped", cap_q.size(), 1);
    check("full_pp_drop_cnt", drop_cnt, ExpDrops);
    drain("full_pp");
    compare("full_pp");

    // vsync discards a partial byte.
    step(0, 1, 0, 2'd0, 1);
    pixels(2, 2'd1, 1);
    step(0, 1, 0, 2'd0, 1);
    pixels(4, 2'd3, 1);
    exp_q.push_back(10'h3FF);
    drain("vs_discard");
    compare("vs_discard");

    // Pixels coinciding with vsync / hsync belong to the new frame / line.
    step(0, 1, 1, 2'd2, 1);
    pixels(3, 2'd1, 1);
    pixels(1, 2'd3, 1);
    step(1, 0, 1, 2'd1, 1);
    pixels(3, 2'd0, 1);
    exp_q.push_back(10'h395);
    exp_q.push_back(10'h0C0);
    exp_q.push_back(10'h140);
    drain("coincide");
    compare("coincide");

    // Reset mid-line with 5 bytes buffered.
    step(0, 1, 0, 2'd0, 0);
    pixels(20, 2'd2, 0);
    step(0, 0, 1, 2'd1, 0);
    step(0, 0, 0, 2'd0, 0);
    check("mid_rst_prefill_valid", byte_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", byte_valid, 0);
    check("mid_rst_data", byte_data, 0);
    check("mid_rst_drop_cnt", drop_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    pixels(8, 2'd3, 1);
    step(1, 0, 0, 2'd0, 1);
    pixels(4, 2'd1, 1);
    repeat (3) step(0, 0, 0, 2'd0, 1);
    check("post_rst_no_output", cap_q.size(), 0);
    check("post_rst_valid", byte_valid, 0);
    step(0, 1, 0, 2'd0, 1);
    pixels(4, 2'd1, 1);
    exp_q.push_back(10'h355);
    drain("post_rst");
    compare("post_rst");

    // Randomized frames: lines end with hsync, the last line of a frame with vsync.
    for (int f = 0; f < 5; f++) begin
      step(0, 1, 0, 2'd0, rnd_rdy());
      frame_first = 1'b1;
      lines = $urandom_range(2, 5);
      for (int l = 0; l < lines; l++) begin
        drive_line($urandom_range(0, 13), l != (lines - 1), 2, 1);
      end
    end
    step(0, 1, 0, 2'd0, rnd_rdy());
    drain("rand");
    compare("rand");
    check("rand_no_overflow", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
